modulation_transition_scheduler: RTL and testbench

//  Queues host modulation segment-transition requests and issues them one at a time to the modulation swapchain.

---
 rtl/modulation_transition_scheduler_pkg.sv | 33 +++
 rtl/modulation_transition_scheduler_if.sv | 19 +
 rtl/modulation_transition_scheduler_fifo.sv | 66 ++++++
 rtl/modulation_transition_scheduler.sv | 146 ++++++++++++++
 tb/tb_modulation_transition_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modulation_transition_scheduler_pkg.sv
// Shared types and constants for the modulation transition scheduler.
// The optional RUN_FINITE watchdog is enabled by defining MOD_SCHED_TIMEOUT_EN.
package modulation_transition_scheduler_pkg;

    localparam int NumSegment = 2;

    localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_MODE_EXT       = 8'hF0;
    localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

    localparam logic [15:0] RepInfinite = 16'hFFFF;

    typedef struct packed {
        logic        segment;
        logic [7:0]  mode;
        logic [63:0] value;
        logic [15:0] rep;
    } mod_sched_req_t;

    // A finite loop needs a mode that eventually lets the swapchain advance,
    // and GPIO transitions only have four input pins to watch.
    function automatic logic req_rejected(input mod_sched_req_t r);
        logic known_mode;
        known_mode = (r.mode == TRANSITION_MODE_SYNC_IDX) ||
                     (r.mode == TRANSITION_MODE_SYS_TIME) ||
                     (r.mode == TRANSITION_MODE_GPIO);
        return ((r.rep != RepInfinite) && !known_mode) ||
               ((r.mode == TRANSITION_MODE_GPIO) && (r.value > 64'd3));
    endfunction

endpackage

// File: rtl/modulation_transition_scheduler_if.sv
// Host request bus: a push is accepted on a cycle where REQ_VALID and REQ_READY are both high.
interface modulation_transition_scheduler_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_SEGMENT;
    logic [7:0]  REQ_MODE;
    logic [63:0] REQ_VALUE;
    logic [15:0] REQ_REP;

    modport master (
        output REQ_VALID, REQ_SEGMENT, REQ_MODE, REQ_VALUE, REQ_REP,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID, REQ_SEGMENT, REQ_MODE, REQ_VALUE, REQ_REP,
        output REQ_READY
    );
endinterface

// File: rtl/modulation_transition_scheduler_fifo.sv
// Synchronous request FIFO; flush empties it and wins over a same-cycle push.
module mod_sched_fifo
    import modulation_transition_scheduler_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           push,
    input  logic           pop,
    input  logic           flush,
    input  mod_sched_req_t wr_data,
    output mod_sched_req_t rd_data,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(Depth);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    mod_sched_req_t mem_q [Depth];
    mod_sched_req_t mem_d [Depth];
    logic           push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(Depth));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/modulation_transition_scheduler.sv
// Issues queued segment-transition requests to the swapchain one at a time.
// Define MOD_SCHED_TIMEOUT_EN to add the RUN_FINITE watchdog and TIMEOUT flag.
module modulation_transition_scheduler
    import modulation_transition_scheduler_pkg::*;
#(
    parameter int          Depth         = 4,
    parameter logic [31:0] TimeoutCycles = 32'd20000
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    modulation_transition_scheduler_if.slave req_if,
    input  logic                         FLUSH,
    input  logic                         ERR_CLR,
    input  logic                         STOP,
    output logic                         UPDATE_SETTINGS,
    output logic                         REQ_RD_SEGMENT,
    output logic [7:0]                   TRANSITION_MODE,
    output logic [63:0]                  TRANSITION_VALUE,
    output logic [NumSegment-1:0][15:0]  REP,
    output logic                         BUSY,
    output logic                         ERR,
    output logic                         TIMEOUT,
    output logic [2:0]                   STATE_DBG
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_LOAD, ST_FIRE, ST_RUN_FINITE
    } state_t;

    state_t                      state_q, state_d;
    mod_sched_req_t              act_q, act_d, fifo_wr, fifo_rd;
    logic                        update_q, update_d, seg_q, seg_d;
    logic [7:0]                  mode_q, mode_d;
    logic [63:0]                 value_q, value_d;
    logic [NumSegment-1:0][15:0] rep_q, rep_d;
    logic                        err_q, err_d, stop_d_q, fifo_full, fifo_empty, pop;

    assign req_if.REQ_READY = ~fifo_full & ~FLUSH;
    assign fifo_wr = '{segment: req_if.REQ_SEGMENT, mode: req_if.REQ_MODE,
                       value: req_if.REQ_VALUE, rep: req_if.REQ_REP};

    mod_sched_fifo #(.Depth(Depth)) u_fifo (
        .CLK(CLK), .RST_N(RST_N),
        .push(req_if.REQ_VALID & req_if.REQ_READY), .pop(pop), .flush(FLUSH),
        .wr_data(fifo_wr), .rd_data(fifo_rd), .full(fifo_full), .empty(fifo_empty)
    );

`ifdef MOD_SCHED_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    assign TIMEOUT = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign TIMEOUT = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        update_d = 1'b0;
        seg_d    = seg_q;
        mode_d   = mode_q;
        value_d  = value_q;
        rep_d    = rep_q;
        err_d    = ERR_CLR ? 1'b0 : err_q;
        pop      = 1'b0;
`ifdef MOD_SCHED_TIMEOUT_EN
        cnt_d     = '0;
        timeout_d = ERR_CLR ? 1'b0 : timeout_q;
`endif
        case (state_q)
            ST_IDLE: if (!fifo_empty && !FLUSH) begin
                pop     = 1'b1;
                act_d   = fifo_rd;
                state_d = ST_CHECK;
            end
            ST_CHECK: if (req_rejected(act_q)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                rep_d[act_q.segment] = act_q.rep;
                seg_d    = act_q.segment;
                mode_d   = act_q.mode;
                value_d  = act_q.value;
                update_d = 1'b1;
                state_d  = ST_FIRE;
            end
            ST_FIRE: state_d = (act_q.rep == RepInfinite) ? ST_IDLE : ST_RUN_FINITE;
            ST_RUN_FINITE: begin
                // Only a fresh rising edge ends the loop; a level held from FIRE does not.
                if (STOP && !stop_d_q) state_d = ST_IDLE;
`ifdef MOD_SCHED_TIMEOUT_EN
                else if (cnt_q + 32'd1 >= TimeoutCycles) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else cnt_d = cnt_q + 32'd1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            act_q    <= '0;
            update_q <= 1'b0;
            seg_q    <= 1'b0;
            mode_q   <= TRANSITION_MODE_SYNC_IDX;
            value_q  <= '0;
            rep_q    <= {NumSegment{RepInfinite}};
            err_q    <= 1'b0;
            stop_d_q <= 1'b0;
`ifdef MOD_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            update_q <= update_d;
            seg_q    <= seg_d;
            mode_q   <= mode_d;
            value_q  <= value_d;
            rep_q    <= rep_d;
            err_q    <= err_d;
            stop_d_q <= STOP;
`ifdef MOD_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign UPDATE_SETTINGS  = update_q;
    assign REQ_RD_SEGMENT   = seg_q;
    assign TRANSITION_MODE  = mode_q;
    assign TRANSITION_VALUE = value_q;
    assign REP              = rep_q;
    assign ERR              = err_q;
    assign BUSY             = (state_q != ST_IDLE) || !fifo_empty;
    assign STATE_DBG        = state_q;
endmodule

// File: tb/tb_modulation_transition_scheduler.sv
// Directed plus randomized checks of the transition scheduler against a request-level model.
module tb_modulation_transition_scheduler;
    import modulation_transition_scheduler_pkg::*;

    typedef struct {
        logic        seg;
        logic [7:0]  mode;
        logic [63:0] value;
        logic [15:0] rep;
        int          cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0, err_clr = 1'b0, stop = 1'b0;
    logic update, rd_seg, busy, err, timeout;
    logic [7:0]  tmode;
    logic [63:0] tvalue;
    logic [1:0][15:0] rep_w;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    mod_sched_req_t exp_q[$];
    obs_t           obs_q[$];

    modulation_transition_scheduler_if req_if();

    modulation_transition_scheduler #(.Depth(4), .TimeoutCycles(32'd100)) dut (
        .CLK(clk), .RST_N(rst_n), .req_if(req_if),
        .FLUSH(flush), .ERR_CLR(err_clr), .STOP(stop),
        .UPDATE_SETTINGS(update), .REQ_RD_SEGMENT(rd_seg),
        .TRANSITION_MODE(tmode), .TRANSITION_VALUE(tvalue), .REP(rep_w),
        .BUSY(busy), .ERR(err), .TIMEOUT(timeout), .STATE_DBG(state_dbg)
    );

    // clock / reset support
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (update) obs_q.push_back('{rd_seg, tmode, tvalue, rep_w[rd_seg], cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // reference model: which requests the scheduler must refuse
    function automatic bit model_reject(input mod_sched_req_t r);
        bit finite_ok;
        finite_ok = r.mode inside {8'h00, 8'h01, 8'h02};
        if (r.rep != 16'hFFFF && !finite_ok) return 1;
        if (r.mode == 8'h02 && r.value > 3) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: present a request until accepted; acc returns the cycle after acceptance
    task automatic push_req(input mod_sched_req_t r, output int acc);
        int n;
        req_if.REQ_VALID   = 1'b1;
        req_if.REQ_SEGMENT = r.segment;
        req_if.REQ_MODE    = r.mode;
        req_if.REQ_VALUE   = r.value;
        req_if.REQ_REP     = r.rep;
        #1;
        n = 0;
        while (!req_if.REQ_READY && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("push_ready_timeout", 0, 1);
        @(negedge clk);
        acc = cyc;
        req_if.REQ_VALID = 1'b0;
    endtask

    task automatic wait_issue(input int max);
        for (int i = 0; i < max; i++) begin
            if (obs_q.size() > 0) break;
            @(negedge clk);
        end
    endtask

    task automatic check_issue(input string tag, input int base, input int lat);
        obs_t o;
        mod_sched_req_t e;
        chk($sformatf("%s_present", tag), (obs_q.size() > 0 && exp_q.size() > 0), 1);
        if (obs_q.size() == 0 || exp_q.size() == 0) return;
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        chk($sformatf("%s_seg", tag), o.seg, e.segment);
        chk($sformatf("%s_mode", tag), o.mode, e.mode);
        chk($sformatf("%s_value", tag), o.value, e.value);
        chk($sformatf("%s_rep", tag), o.rep, e.rep);
        if (lat >= 0) chk($sformatf("%s_latency", tag), o.cyc - base, lat);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    mod_sched_req_t r, r2;
    int acc, acc2, cs, cf;
    logic [7:0] mode_tab [5];

    initial begin
        mode_tab = '{8'h00, 8'h01, 8'h02, 8'hF0, 8'hFF};
        req_if.REQ_VALID = 1'b0;
        req_if.REQ_SEGMENT = 1'b0;
        req_if.REQ_MODE = 8'h00;
        req_if.REQ_VALUE = '0;
        req_if.REQ_REP = '0;

        // reset state
        tick(3);
        chk("rst_update", update, 0);
        chk("rst_seg", rd_seg, 0);
        chk("rst_mode", tmode, 8'h00);
        chk("rst_value", tvalue, 0);
        chk("rst_rep0", rep_w[0], 16'hFFFF);
        chk("rst_rep1", rep_w[1], 16'hFFFF);
        chk("rst_err", err, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_if.REQ_READY, 1);
        rst_n = 1'b1;
        tick(2);

        // 1: single infinite request passes straight through
        r = '{1'b1, 8'h00, {$urandom, $urandom}, 16'hFFFF};
        exp_q.push_back(r);
        push_req(r, acc);
        wait_issue(10);
        check_issue("t1", acc, 3);
        tick(1);
        chk("t1_pulse_end", update, 0);
        chk("t1_busy_fall", busy, 0);
        chk("t1_seg_held", rd_seg, 1);

        // 2: finite loop holds back the next request until STOP rises
        r = '{1'b0, 8'h01, {$urandom, $urandom}, 16'd2};
        r2 = '{1'b1, 8'h00, {$urandom, $urandom}, 16'hFFFF};
        exp_q.push_back(r);
        exp_q.push_back(r2);
        push_req(r, acc);
        push_req(r2, acc2);
        wait_issue(10);
        check_issue("t2a", acc, 3);
        tick(20);
        chk("t2_held", obs_q.size(), 0);
        chk("t2_busy", busy, 1);
        stop = 1'b1;
        cs = cyc;
        wait_issue(10);
        check_issue("t2b", cs, 4);
        chk("t2_rep0", rep_w[0], 16'd2);
        stop = 1'b0;
        tick(2);
        chk("t2_idle", busy, 0);

        // 3: STOP already high at FIRE must fall and rise again
        stop = 1'b1;
        r = '{1'b1, 8'h02, 64'd2, 16'd5};
        r2 = '{1'b0, 8'h01, {$urandom, $urandom}, 16'hFFFF};
        exp_q.push_back(r);
        exp_q.push_back(r2);
        push_req(r, acc);
        push_req(r2, acc2);
        wait_issue(10);
        check_issue("t3a", acc, 3);
        tick(10);
        stop = 1'b0;
        tick(50);
        chk("t3_held", obs_q.size(), 0);
        stop = 1'b1;
        cs = cyc;
        wait_issue(10);
        check_issue("t3b", cs, 4);
        stop = 1'b0;
        tick(2);

        // 4: rejections and their boundaries
        r = '{1'b0, 8'hF0, {$urandom, $urandom}, 16'd3};
        push_req(r, acc);
        tick(10);
        chk("t4_ext_noissue", obs_q.size(), 0);
        chk("t4_ext_err", err, 1);
        chk("t4_ext_busy", busy, 0);
        pulse_err_clr();
        chk("t4_errclr", err, 0);
        r = '{1'b1, 8'h02, 64'd5, 16'hFFFF};
        push_req(r, acc);
        tick(10);
        chk("t4_gpio_noissue", obs_q.size(), 0);
        chk("t4_gpio_err", err, 1);
        pulse_err_clr();
        r = '{1'b0, 8'hF0, {$urandom, $urandom}, 16'hFFFF};
        exp_q.push_back(r);
        push_req(r, acc);
        wait_issue(10);
        check_issue("t4_ext_inf", acc, 3);
        r = '{1'b1, 8'h02, 64'd3, 16'd7};
        exp_q.push_back(r);
        push_req(r, acc);
        wait_issue(10);
        check_issue("t4_gpio3", acc, 3);
        tick(2);
        pulse_stop();
        tick(3);
        chk("t4_err_clean", err, 0);
        chk("t4_idle", busy, 0);

        // 5: full FIFO, then FLUSH with a same-cycle push
        r = '{1'b0, 8'h00, {$urandom, $urandom}, 16'd1};
        exp_q.push_back(r);
        push_req(r, acc);
        wait_issue(10);
        check_issue("t5_active", acc, 3);
        for (int i = 0; i < 4; i++) begin
            r2 = '{1'b1, 8'h01, {$urandom, $urandom}, 16'hFFFF};
            push_req(r2, acc2);
        end
        #1;
        chk("t5_full_ready", req_if.REQ_READY, 0);
        req_if.REQ_VALID = 1'b1;
        req_if.REQ_SEGMENT = 1'b1;
        req_if.REQ_REP = 16'hFFFF;
        tick(1);
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", req_if.REQ_READY, 0);
        tick(1);
        flush = 1'b0;
        req_if.REQ_VALID = 1'b0;
        #1;
        chk("t5_after_ready", req_if.REQ_READY, 1);
        chk("t5_active_busy", busy, 1);
        chk("t5_active_seg", rd_seg, 0);
        chk("t5_active_rep", rep_w[0], 16'd1);
        pulse_stop();
        tick(12);
        chk("t5_flushed", obs_q.size(), 0);
        chk("t5_idle", busy, 0);

        // randomized requests against the model
        for (int k = 0; k < 24; k++) begin
            pulse_err_clr();
            r.segment = 1'($urandom_range(0, 1));
            r.mode = mode_tab[$urandom_range(0, 4)];
            r.value = (r.mode == 8'h02) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
            r.rep = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom_range(0, 10));
            if (model_reject(r)) begin
                push_req(r, acc);
                tick(8);
                chk("rnd_rej_noissue", obs_q.size(), 0);
                chk("rnd_rej_err", err, 1);
            end else begin
                exp_q.push_back(r);
                push_req(r, acc);
                wait_issue(10);
                check_issue("rnd_issue", acc, 3);
                if (r.rep != 16'hFFFF) begin
                    tick(3);
                    chk("rnd_finite_busy", busy, 1);
                    pulse_stop();
                end
                tick(3);
                chk("rnd_err", err, 0);
            end
            chk("rnd_idle", busy, 0);
        end

        // 6: watchdog on a finite loop with STOP static
        r = '{1'b0, 8'h01, {$urandom, $urandom}, 16'd9};
        r2 = '{1'b1, 8'h00, {$urandom, $urandom}, 16'hFFFF};
        exp_q.push_back(r);
        exp_q.push_back(r2);
        push_req(r, acc);
        push_req(r2, acc2);
        wait_issue(10);
        cf = cyc;
        check_issue("t6a", acc, 3);
`ifdef MOD_SCHED_TIMEOUT_EN
        tick(90);
        chk("t6_no_early_timeout", timeout, 0);
        for (int i = 0; i < 30; i++) begin
            if (timeout) break;
            @(negedge clk);
        end
        chk("t6_timeout", timeout, 1);
        wait_issue(20);
        check_issue("t6b", 0, -1);
        pulse_err_clr();
        chk("t6_timeout_clr", timeout, 0);
`else
        tick(150);
        chk("t6_noissue", obs_q.size(), 0);
        chk("t6_timeout_zero", timeout, 0);
        chk("t6_still_busy", busy, 1);
        stop = 1'b1;
        cs = cyc;
        wait_issue(10);
        check_issue("t6b", cs, 4);
        stop = 1'b0;
`endif
        tick(3);

        // 7: reset while a finite loop runs with queued requests
        r = '{1'b1, 8'h02, 64'd9, 16'hFFFF};
        push_req(r, acc);
        tick(8);
        r = '{1'b1, 8'h01, {$urandom, $urandom} | 64'h1, 16'd4};
        exp_q.push_back(r);
        push_req(r, acc);
        wait_issue(10);
        check_issue("t7_active", acc, 3);
        for (int i = 0; i < 2; i++) begin
            r2 = '{1'b0, 8'h00, {$urandom, $urandom}, 16'hFFFF};
            push_req(r2, acc2);
        end
        tick(2);
        chk("t7_pre_err", err, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_update", update, 0);
        chk("t7_seg", rd_seg, 0);
        chk("t7_mode", tmode, 8'h00);
        chk("t7_value", tvalue, 0);
        chk("t7_rep0", rep_w[0], 16'hFFFF);
        chk("t7_rep1", rep_w[1], 16'hFFFF);
        chk("t7_err", err, 0);
        chk("t7_timeout", timeout, 0);
        chk("t7_busy", busy, 0);
        chk("t7_ready", req_if.REQ_READY, 1);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk("t7_fifo_empty", obs_q.size(), 0);
        chk("t7_idle", busy, 0);
        chk("final_exp_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
